// File: rtl/spi_ram_access_arbiter.sv
// spi_ram_access_arbiter
// Arbitrates one registered-read RAM port between a buffered SPI command
// path and a level-requesting local fabric client. SPI has fixed priority.
// A starvation counter forces a local grant after STARVE_LIMIT SPI grants
// that were taken while the local side was waiting.
module spi_ram_access_arbiter #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spi_request,
  input  logic                  spi_write,
  input  logic [ADDR_WIDTH-1:0] spi_address,
  input  logic [DATA_WIDTH-1:0] spi_data,
  output logic [DATA_WIDTH-1:0] spi_read_data,
  output logic                  spi_done,
  output logic                  spi_overflow,
  input  logic                  local_request,
  input  logic                  local_write,
  input  logic [ADDR_WIDTH-1:0] local_address,
  input  logic [DATA_WIDTH-1:0] local_data,
  output logic [DATA_WIDTH-1:0] local_read_data,
  output logic                  local_ack,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_SPI   = 2'd1,
    GRANT_LOCAL = 2'd2,
    READ_WAIT   = 2'd3
  } state_t;

  state_t                  state;
  logic                    pend_valid;
  logic                    pend_write;
  logic [ADDR_WIDTH-1:0]   pend_address;
  logic [DATA_WIDTH-1:0]   pend_data;
  logic [STARVE_WIDTH-1:0] starve;
  logic                    grant_is_write;
  logic                    read_for_spi;

  logic                    grant_pend;
  logic                    grant_bypass;
  logic                    grant_spi;
  logic                    grant_local;
  logic                    spi_sel_write;
  logic [ADDR_WIDTH-1:0]   spi_sel_address;
  logic [DATA_WIDTH-1:0]   spi_sel_data;

  // Grant decision in IDLE. A fresh SPI pulse is taken directly only when
  // the buffer is empty and the local side is quiet; otherwise it waits in
  // the buffer and competes next time the arbiter is idle.
  always_comb begin
    grant_pend   = 1'b0;
    grant_bypass = 1'b0;
    grant_local  = 1'b0;
    if (state == IDLE) begin
      if (pend_valid && (!local_request || (starve < STARVE_MAX))) begin
        grant_pend = 1'b1;
      end else if (!pend_valid && spi_request && !local_request) begin
        grant_bypass = 1'b1;
      end else if (local_request) begin
        grant_local = 1'b1;
      end else begin
        grant_local = 1'b0;
      end
    end else begin
      grant_pend = 1'b0;
    end
    grant_spi = grant_pend | grant_bypass;
    if (pend_valid) begin
      spi_sel_write   = pend_write;
      spi_sel_address = pend_address;
      spi_sel_data    = pend_data;
    end else begin
      spi_sel_write   = spi_write;
      spi_sel_address = spi_address;
      spi_sel_data    = spi_data;
    end
  end

  // One-entry SPI buffer; a request that finds it full and not draining is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_valid   <= 1'b0;
      pend_write   <= 1'b0;
      pend_address <= {ADDR_WIDTH{1'b0}};
      pend_data    <= {DATA_WIDTH{1'b0}};
      spi_overflow <= 1'b0;
    end else if (spi_request && !grant_bypass) begin
      if (!pend_valid || grant_pend) begin
        pend_valid   <= 1'b1;
        pend_write   <= spi_write;
        pend_address <= spi_address;
        pend_data    <= spi_data;
      end else begin
        spi_overflow <= 1'b1;
      end
    end else if (grant_pend) begin
      pend_valid <= 1'b0;
    end else begin
      pend_valid <= pend_valid;
    end
  end

  // Count SPI grants taken while the local side waits; saturates at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve <= {STARVE_WIDTH{1'b0}};
    end else if (!local_request || grant_local) begin
      starve <= {STARVE_WIDTH{1'b0}};
    end else if (grant_spi && (starve != STARVE_MAX)) begin
      starve <= starve + STARVE_WIDTH'(1);
    end else begin
      starve <= starve;
    end
  end

  // Arbiter FSM with registered RAM port and completion outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      grant_is_write   <= 1'b0;
      read_for_spi     <= 1'b0;
      spi_read_data    <= {DATA_WIDTH{1'b0}};
      spi_done         <= 1'b0;
      local_read_data  <= {DATA_WIDTH{1'b0}};
      local_ack        <= 1'b0;
      ram_address      <= {ADDR_WIDTH{1'b0}};
      ram_data_in      <= {DATA_WIDTH{1'b0}};
      ram_write_enable <= 1'b0;
    end else begin
      spi_done         <= 1'b0;
      local_ack        <= 1'b0;
      ram_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_spi) begin
            state            <= GRANT_SPI;
            grant_is_write   <= spi_sel_write;
            ram_address      <= spi_sel_address;
            ram_data_in      <= spi_sel_data;
            ram_write_enable <= spi_sel_write;
          end else if (grant_local) begin
            state            <= GRANT_LOCAL;
            grant_is_write   <= local_write;
            ram_address      <= local_address;
            ram_data_in      <= local_data;
            ram_write_enable <= local_write;
          end else begin
            state <= IDLE;
          end
        end
        GRANT_SPI: begin
          if (grant_is_write) begin
            state    <= IDLE;
            spi_done <= 1'b1;
          end else begin
            state        <= READ_WAIT;
            read_for_spi <= 1'b1;
          end
        end
        GRANT_LOCAL: begin
          if (grant_is_write) begin
            state     <= IDLE;
            local_ack <= 1'b1;
          end else begin
            state        <= READ_WAIT;
            read_for_spi <= 1'b0;
          end
        end
        READ_WAIT: begin
          state <= IDLE;
          if (read_for_spi) begin
            spi_read_data <= ram_data_out;
            spi_done      <= 1'b1;
          end else begin
            local_read_data <= ram_data_out;
            local_ack       <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_access_arbiter.sv
// Scoreboard bench for spi_ram_access_arbiter: drivers push expected
// completion cycle and read-data value; a monitor pops on spi_done/local_ack.
module tb_spi_ram_access_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic        spi_request = 1'b0, spi_write = 1'b0;
  logic [8:0]  spi_address = 9'h000;
  logic [31:0] spi_data = 32'h0;
  logic [31:0] spi_read_data;
  logic        spi_done, spi_overflow;
  logic        local_request = 1'b0, local_write = 1'b0;
  logic [8:0]  local_address = 9'h000;
  logic [31:0] local_data = 32'h0;
  logic [31:0] local_read_data;
  logic        local_ack;
  logic [8:0]  ram_address;
  logic [31:0] ram_data_in;
  logic        ram_write_enable;
  logic [31:0] ram_data_out;

  spi_ram_access_arbiter dut (
    .clock(clock), .reset(reset),
    .spi_request(spi_request), .spi_write(spi_write), .spi_address(spi_address),
    .spi_data(spi_data), .spi_read_data(spi_read_data), .spi_done(spi_done),
    .spi_overflow(spi_overflow),
    .local_request(local_request), .local_write(local_write),
    .local_address(local_address), .local_data(local_data),
    .local_read_data(local_read_data), .local_ack(local_ack),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
  );

  always #5 clock = ~clock;

  // Registered-read RAM model, preloaded with 0xA000_0000 + address.
  logic [31:0] mem [0:511];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else begin
      if (ram_write_enable) mem[ram_address] <= ram_data_in;
      ram_data_out <= mem[ram_address];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          when;
    logic [31:0] data;
  } exp_t;

  exp_t        spi_q[$];
  exp_t        loc_q[$];
  logic [31:0] spi_model = 32'h0;
  logic [31:0] loc_model = 32'h0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          we_count = 0;
  int          we_before;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on each completion pulse.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (ram_write_enable) we_count++;
    if (!reset) begin
      if (spi_done) begin
        if (spi_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spi_done_unexpected: got spi_done at cycle %0d, expected none", cyc);
        end else begin
          e = spi_q.pop_front();
          check("spi_done_cycle", 64'(cyc), 64'(e.when));
          check("spi_read_data", 64'(spi_read_data), 64'(e.data));
        end
      end
      if (local_ack) begin
        if (loc_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL local_ack_unexpected: got local_ack at cycle %0d, expected none", cyc);
        end else begin
          e = loc_q.pop_front();
          check("local_ack_cycle", 64'(cyc), 64'(e.when));
          check("local_read_data", 64'(local_read_data), 64'(e.data));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One-cycle SPI pulse; lat < 0 marks a request expected to be dropped.
  task automatic spi_send(input logic w, input logic [8:0] a, input logic [31:0] d,
                          input int lat, input logic [31:0] exp_rd);
    exp_t e;
    spi_request = 1'b1; spi_write = w; spi_address = a; spi_data = d;
    if (lat >= 0) begin
      if (!w) spi_model = exp_rd;
      e.when = cyc + lat;
      e.data = spi_model;
      spi_q.push_back(e);
    end
    @(negedge clock);
    spi_request = 1'b0;
  endtask

  // Level local request held until local_ack, bounded wait.
  task automatic local_access(input logic w, input logic [8:0] a, input logic [31:0] d,
                              input int lat, input logic [31:0] exp_rd);
    exp_t e;
    logic got;
    got = 1'b0;
    local_request = 1'b1; local_write = w; local_address = a; local_data = d;
    if (!w) loc_model = exp_rd;
    e.when = cyc + lat;
    e.data = loc_model;
    loc_q.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (local_ack) begin
        got = 1'b1;
        break;
      end
    end
    local_request = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL local_ack_timeout: got no ack in 40 cycles, expected ack for addr %0h", a);
    end
  endtask

  initial begin
    step(3);
    check("reset_spi_done", 64'(spi_done), 64'(0));
    check("reset_spi_overflow", 64'(spi_overflow), 64'(0));
    check("reset_local_ack", 64'(local_ack), 64'(0));
    check("reset_ram_we", 64'(ram_write_enable), 64'(0));
    check("reset_ram_address", 64'(ram_address), 64'(0));
    mem_init = 1'b0;
    reset = 1'b0;
    step(2);

    // SPI write then read of the same address, idle arbiter.
    spi_send(1'b1, 9'h1A5, 32'hDEADBEEF, 2, 32'h0);
    step(1);
    spi_send(1'b0, 9'h1A5, 32'h0, 3, 32'hDEADBEEF);
    step(6);

    // Local write then read; exactly one write-enable pulse.
    we_before = we_count;
    local_access(1'b1, 9'h003, 32'h12345678, 2, 32'h0);
    local_access(1'b0, 9'h003, 32'h0, 3, 32'h12345678);
    step(4);
    check("local_write_we_pulses", 64'(we_count - we_before), 64'(1));

    // Starvation guard: local waits through four SPI grants.
    fork
      begin
        spi_send(1'b0, 9'h020, 32'h0, 3, 32'hA000_0020);
        spi_send(1'b0, 9'h021, 32'h0, 5, 32'hA000_0021);
        step(2);
        spi_send(1'b0, 9'h022, 32'h0, 5, 32'hA000_0022);
        step(2);
        spi_send(1'b0, 9'h023, 32'h0, 5, 32'hA000_0023);
        step(2);
        spi_send(1'b0, 9'h024, 32'h0, 5, 32'hA000_0024);
        step(2);
        spi_send(1'b0, 9'h025, 32'h0, 8, 32'hA000_0025);
      end
      begin
        step(1);
        local_access(1'b0, 9'h030, 32'h0, 17, 32'hA000_0030);
      end
    join
    step(8);

    // Pending entry granted and reloaded in the same cycle: no overflow.
    fork
      local_access(1'b0, 9'h031, 32'h0, 3, 32'hA000_0031);
      begin
        step(1);
        spi_send(1'b1, 9'h060, 32'h33333333, 4, 32'h0);
        step(1);
        spi_send(1'b1, 9'h061, 32'h44444444, 4, 32'h0);
      end
    join
    step(6);
    check("no_overflow_on_reload", 64'(spi_overflow), 64'(0));

    // Second SPI pulse while buffer full and local holds the RAM: dropped.
    fork
      local_access(1'b0, 9'h032, 32'h0, 3, 32'hA000_0032);
      begin
        step(1);
        spi_send(1'b1, 9'h040, 32'h11111111, 4, 32'h0);
        spi_send(1'b1, 9'h050, 32'h22222222, -1, 32'h0);
      end
    join
    check("overflow_set", 64'(spi_overflow), 64'(1));
    step(6);
    check("overflow_sticky", 64'(spi_overflow), 64'(1));

    // Simultaneous SPI write and local read of 0x010: local sees old data.
    fork
      spi_send(1'b1, 9'h010, 32'h5555AAAA, 5, 32'h0);
      local_access(1'b0, 9'h010, 32'h0, 3, 32'hA000_0010);
    join
    step(6);
    spi_send(1'b0, 9'h010, 32'h0, 3, 32'h5555AAAA);
    step(6);

    // Reset asserted while a local read sits in READ_WAIT.
    local_request = 1'b1; local_write = 1'b0; local_address = 9'h070;
    step(2);
    reset = 1'b1;
    #1;
    check("async_spi_read_data", 64'(spi_read_data), 64'(0));
    check("async_spi_done", 64'(spi_done), 64'(0));
    check("async_spi_overflow", 64'(spi_overflow), 64'(0));
    check("async_local_read_data", 64'(local_read_data), 64'(0));
    check("async_local_ack", 64'(local_ack), 64'(0));
    check("async_ram_address", 64'(ram_address), 64'(0));
    check("async_ram_data_in", 64'(ram_data_in), 64'(0));
    check("async_ram_we", 64'(ram_write_enable), 64'(0));
    local_request = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    spi_model = 32'h0;
    loc_model = 32'h0;
    step(4);

    // Read back RAM after reset, including the dropped write address.
    spi_send(1'b0, 9'h070, 32'h0, 3, 32'hA000_0070);
    step(5);
    spi_send(1'b0, 9'h050, 32'h0, 3, 32'hA000_0050);
    step(5);
    spi_send(1'b0, 9'h040, 32'h0, 3, 32'h11111111);
    step(5);
    local_access(1'b0, 9'h060, 32'h0, 3, 32'h33333333);
    local_access(1'b0, 9'h061, 32'h0, 3, 32'h44444444);
    step(5);

    check("spi_queue_drained", 64'(spi_q.size()), 64'(0));
    check("local_queue_drained", 64'(loc_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
